serial_word_receiver: RTL

//  Serial-to-parallel receiver for the S_OUT stream of the 4-bit shift register (serial link).

---
 rtl/serial_word_receiver_if.sv | 42 ++++
 rtl/serial_word_receiver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver_if.sv
//==============================================================================
// Module      : serial_word_receiver_if
// Description : Bundle of the serial bit stream, the word-level VALID/READY
//               handshake and the status flags of serial_word_receiver.
//               master : serial source plus parallel consumer (drives ENB,
//                        S_IN, DIR, SYNC, READY; observes Q and the flags)
//               slave  : the receiver itself
// Signals     : ENB   bit strobe            S_IN  serial data
//               DIR   bit order per word    SYNC  word realign
//               READY consumer accept       Q     received word [WIDTH]
//               VALID Q holds a word        BUSY  word partially received
//               OVR   sticky overrun        PERR  parity error of word on Q
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             ENB;
    logic             S_IN;
    logic             DIR;
    logic             SYNC;
    logic             READY;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             BUSY;
    logic             OVR;
    logic             PERR;

    modport master (
        output ENB, S_IN, DIR, SYNC, READY,
        input  Q, VALID, BUSY, OVR, PERR
    );

    modport slave (
        input  ENB, S_IN, DIR, SYNC, READY,
        output Q, VALID, BUSY, OVR, PERR
    );
endinterface

`default_nettype wire

// File: rtl/serial_word_receiver.sv
//==============================================================================
// Module      : serial_word_receiver
// Description : Serial-to-parallel receiver. Collects WIDTH bits qualified by
//               ENB, assembles them LSB- or MSB-first (DIR latched with the
//               first bit of each word) and presents the word on Q with a
//               VALID/READY handshake. A word completing while an unconsumed
//               word is held and READY=0 is discarded and sets sticky OVR.
//               SYNC aborts a partial word (and, with ENB, starts a new one).
// Ports       : clk    clock, rising edge
//               reset  synchronous active-high reset
//               bus    serial_word_receiver_if.slave (ENB, S_IN, DIR, SYNC,
//                      READY in; Q, VALID, BUSY, OVR, PERR out)
// Parameters  : WIDTH       data bits per word (>= 2)
//               ODD_PARITY  0 even / 1 odd parity sense
// Config      : define PARITY_CHECK_EN to append a parity bit to every word
//               and report PERR; undefined -> PERR tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_word_receiver #(
    parameter int WIDTH      = 4,
    parameter int ODD_PARITY = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    serial_word_receiver_if.slave bus
);

    localparam int             CW             = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_last_idx     = CW'(WIDTH - 1);
    localparam logic           c_parity_sense = 1'(ODD_PARITY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_dir;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_busy;
    logic             r_ovr;
    logic             r_perr;

    logic             w_start;
    logic             w_dir;
    logic [CW-1:0]    w_idx;
    logic [CW-1:0]    w_pos;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_word;
    logic             w_data_bit;
    logic             w_last_data;
    logic             w_to_par;
    logic             w_complete;
    logic [WIDTH-1:0] w_word_out;
    logic             w_perr;

    always_comb begin
        // A strobe in IDLE, or any strobe together with SYNC, opens a new word:
        // bit index 0, fresh data, DIR taken from the current input.
        w_start = bus.ENB & (bus.SYNC | (r_state == ST_IDLE));
        w_dir   = w_start ? bus.DIR : r_dir;
        w_idx   = w_start ? '0 : r_count;
        w_base  = w_start ? '0 : r_data;
        w_pos   = w_dir ? (c_last_idx - w_idx) : w_idx;

        w_word = w_base;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_pos == CW'(k)) begin
                w_word[k] = bus.S_IN;
            end
        end

        // In PAR the strobed bit is parity, not data.
        w_data_bit  = bus.ENB & (w_start | (r_state == ST_RECV));
        w_last_data = w_data_bit & (w_idx == c_last_idx);

`ifdef PARITY_CHECK_EN
        w_to_par   = w_last_data;
        w_complete = bus.ENB & ~bus.SYNC & (r_state == ST_PAR);
        w_word_out = r_data;
        w_perr     = ((^r_data) ^ bus.S_IN) != c_parity_sense;
`else
        w_to_par   = 1'b0;
        w_complete = w_last_data;
        w_word_out = w_word;
        w_perr     = 1'b0;
`endif
    end

`ifndef PARITY_CHECK_EN
    // Parity sense has no effect without the parity bit.
    logic w_unused_parity_sense;
    assign w_unused_parity_sense = c_parity_sense;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_data  <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            // Bit-level sequencing
            if (w_complete) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else if (w_data_bit) begin
                r_state <= w_to_par ? ST_PAR : ST_RECV;
                r_count <= w_idx + CW'(1);
                r_data  <= w_word;
                r_dir   <= w_dir;
                r_busy  <= 1'b1;
            end else if (bus.SYNC) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end

            // Word-level handshake: a completing word either replaces the
            // held one (free slot or consumed this edge) or is dropped.
            if (w_complete) begin
                if (r_valid & ~bus.READY) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_q     <= w_word_out;
                    r_perr  <= w_perr;
                    r_valid <= 1'b1;
                end
            end else if (r_valid & bus.READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.Q     = r_q;
    assign bus.VALID = r_valid;
    assign bus.BUSY  = r_busy;
    assign bus.OVR   = r_ovr;
    assign bus.PERR  = r_perr;

endmodule

`default_nettype wire
